// File: rtl/ripple_count_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_count_sampler_pkg
//  Description : Shared definitions for the ripple counter sampler: FSM state
//                encoding and default widths and filter depth.
//  Revision    : 1.0  initial release
// ============================================================================
package ripple_count_sampler_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_EXT_WIDTH  = 4;
    localparam int DEF_STABLE_CNT = 2;

    // ACQ waits for the first settled value; TRACK follows subsequent changes.
    typedef enum logic [0:0] {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage : ripple_count_sampler_pkg
`default_nettype wire

// File: rtl/ripple_count_sampler_bus_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sync2
//  Description : Two-flop synchronizer for a bus of asynchronous inputs.
//                Individual bits may resolve on different cycles; the
//                downstream stability filter is what removes incoherent values.
//  Ports       : clk  - destination clock
//                rst  - synchronous reset, active-low
//                d    - asynchronous input bus
//                q    - synchronized output bus (second flop stage)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule : bus_sync2
`default_nettype wire

// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_count_sampler
//  Description : Resamples the outputs of an asynchronous ripple up counter,
//                filters out transient values, extends the accepted value with
//                a wrap counter and publishes it over valid/ready. Flags
//                skipped counts and lost updates with sticky error bits.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous reset, active-low
//                q_in       - raw ripple counter outputs (asynchronous)
//                clr_err    - clear skip_err / ovr_err
//                cnt_ready  - consumer accepts cnt_o this cycle
//                cnt_valid  - cnt_o holds an unconsumed update
//                cnt_o      - {wrap extension, accepted value}
//                skip_err   - sticky: accepted value was not previous+1
//                ovr_err    - sticky: update overwrote an unconsumed one
//  Revision    : 1.0  initial release
// ============================================================================
module ripple_count_sampler
    import ripple_count_sampler_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXT_WIDTH  = DEF_EXT_WIDTH,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           q_in,
    input  logic                       clr_err,
    input  logic                       cnt_ready,
    output logic                       cnt_valid,
    output logic [WIDTH+EXT_WIDTH-1:0] cnt_o,
    output logic                       skip_err,
    output logic                       ovr_err
);

    localparam int                STAB_W   = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);

    // ------------------------------------------------------------------
    // Synchronizer. A constant-1 marker bit travels alongside the data so
    // the filter ignores the zeros flushed out of the flops after reset;
    // otherwise those zeros would look like a settled value of 0.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sync_out;
    logic             s2_vld;
    logic [WIDTH-1:0] s2;

    bus_sync2 #(
        .WIDTH (WIDTH + 1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({1'b1, q_in}),
        .q   (sync_out)
    );

    assign s2_vld = sync_out[WIDTH];
    assign s2     = sync_out[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  prev;
    logic              prev_vld;
    logic [STAB_W-1:0] stab;
    logic [STAB_W-1:0] stab_next;
    logic              settled;

    always_comb begin
        stab_next = '0;
        if (!s2_vld) begin
            stab_next = '0;
        end else if (prev_vld && (s2 == prev)) begin
            stab_next = (stab == STAB_MAX) ? stab : stab + 1'b1;
        end else begin
            stab_next = STAB_W'(1);
        end
    end

    // Using the next count lets the update land in the same edge that
    // completes the run, giving STABLE_CNT+2 cycles of latency.
    assign settled = (stab_next == STAB_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev     <= '0;
            prev_vld <= 1'b0;
            stab     <= '0;
        end else begin
            prev     <= s2;
            prev_vld <= s2_vld;
            stab     <= stab_next;
        end
    end

    // ------------------------------------------------------------------
    // Acceptance FSM
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     acc_inc;
    logic [EXT_WIDTH-1:0] ext;
    logic [EXT_WIDTH-1:0] ext_next;
    logic                 push;
    logic                 skip_set;
    logic                 ovr_set;

    assign acc_inc = acc + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        ext_next   = ext;
        skip_set   = 1'b0;
        unique case (state)
            ACQ: begin
                if (settled) begin
                    push       = 1'b1;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (settled && (s2 != acc)) begin
                    push = 1'b1;
                    if (s2 < acc) begin
                        ext_next = ext + 1'b1;
                    end
                    if (s2 != acc_inc) begin
                        skip_set = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ACQ;
            end
        endcase
    end

    assign ovr_set = push && cnt_valid && !cnt_ready;

    // ------------------------------------------------------------------
    // Accepted value, extension, output register and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            ext       <= '0;
            cnt_o     <= '0;
            cnt_valid <= 1'b0;
            skip_err  <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            if (push) begin
                acc       <= s2;
                ext       <= ext_next;
                cnt_o     <= {ext_next, s2};
                cnt_valid <= 1'b1;
            end else if (cnt_valid && cnt_ready) begin
                cnt_valid <= 1'b0;
            end
            // A new error event takes priority over a simultaneous clear.
            skip_err <= (skip_err && !clr_err) || skip_set;
            ovr_err  <= (ovr_err  && !clr_err) || ovr_set;
        end
    end

endmodule : ripple_count_sampler
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ripple_count_sampler
//  Description : Directed self-checking bench for ripple_count_sampler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ripple_count_sampler;

    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic       clr_err;
    logic       cnt_ready;
    logic       cnt_valid;
    logic [7:0] cnt_o;
    logic       skip_err;
    logic       ovr_err;

    int n_cmp;
    int n_err;
    int n_upd;
    int n_glitch;

    ripple_count_sampler #(
        .WIDTH      (4),
        .EXT_WIDTH  (4),
        .STABLE_CNT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .clr_err   (clr_err),
        .cnt_ready (cnt_ready),
        .cnt_valid (cnt_valid),
        .cnt_o     (cnt_o),
        .skip_err  (skip_err),
        .ovr_err   (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count consumed updates and any published value with low nibble 2.
    always @(negedge clk) begin
        if (cnt_valid && cnt_ready) n_upd++;
        if (cnt_valid && (cnt_o[3:0] == 4'h2)) n_glitch++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_upd;
        int base_gl;
        logic [7:0] exp_cnt;

        n_cmp = 0; n_err = 0;
        rst = 1'b0; q_in = 4'h7; clr_err = 1'b0; cnt_ready = 1'b1;

        // ---- 1. reset and first acquisition ----
        step(3);
        check("rst_valid", 32'(cnt_valid), 32'd0);
        check("rst_cnt",   32'(cnt_o),     32'h00);
        check("rst_skip",  32'(skip_err),  32'd0);
        check("rst_ovr",   32'(ovr_err),   32'd0);
        rst = 1'b1;
        step(3);
        check("acq_early_valid", 32'(cnt_valid), 32'd0);
        step(1);
        check("acq_valid", 32'(cnt_valid), 32'd1);
        check("acq_cnt",   32'(cnt_o),     32'h07);
        check("acq_skip",  32'(skip_err),  32'd0);

        // ---- 2. count 0..15..0..3 from a fresh reset ----
        rst = 1'b0; q_in = 4'h0;
        step(2);
        base_upd = n_upd;
        rst = 1'b1;
        step(8);
        check("cnt_0", 32'(cnt_o), 32'h00);
        for (int i = 1; i < 20; i++) begin
            exp_cnt = 8'(i);
            q_in = exp_cnt[3:0];
            step(8);
            check($sformatf("cnt_%0d", i), 32'(cnt_o), 32'(exp_cnt));
        end
        check("cnt_updates", 32'(n_upd - base_upd), 32'd20);
        check("cnt_skip",    32'(skip_err), 32'd0);
        check("cnt_ovr",     32'(ovr_err),  32'd0);

        // ---- 3. glitch rejection ----
        base_upd = n_upd; base_gl = n_glitch;
        q_in = 4'h2;
        step(1);
        q_in = 4'h4;
        step(8);
        check("gl_updates", 32'(n_upd - base_upd), 32'd1);
        check("gl_cnt",     32'(cnt_o), 32'h14);
        check("gl_seen2",   32'(n_glitch - base_gl), 32'd0);
        check("gl_skip",    32'(skip_err), 32'd0);

        // ---- 4. skip detection and sticky clear ----
        q_in = 4'h5;
        step(8);
        check("sk_cnt5",  32'(cnt_o),    32'h15);
        check("sk_skip0", 32'(skip_err), 32'd0);
        q_in = 4'h8;
        step(8);
        check("sk_cnt8",  32'(cnt_o),    32'h18);
        check("sk_skip1", 32'(skip_err), 32'd1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("sk_clr",   32'(skip_err), 32'd0);
        q_in = 4'hA;
        step(3);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("sk_setwins", 32'(skip_err), 32'd1);
        check("sk_cntA",    32'(cnt_o),    32'h1A);

        // ---- 5. overrun ----
        rst = 1'b0; q_in = 4'h1;
        step(2);
        rst = 1'b1;
        step(8);
        check("ov_cnt1",   32'(cnt_o),     32'h01);
        check("ov_drain",  32'(cnt_valid), 32'd0);
        cnt_ready = 1'b0;
        q_in = 4'h2;
        step(8);
        check("ov_cnt2",   32'(cnt_o),     32'h02);
        check("ov_hold",   32'(cnt_valid), 32'd1);
        check("ov_none",   32'(ovr_err),   32'd0);
        q_in = 4'h3;
        step(8);
        check("ov_cnt3",   32'(cnt_o),     32'h03);
        check("ov_set",    32'(ovr_err),   32'd1);
        check("ov_valid",  32'(cnt_valid), 32'd1);
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
        check("ov_consume", 32'(cnt_valid), 32'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("ov_clr",    32'(ovr_err),   32'd0);
        q_in = 4'h4;
        step(8);
        check("ov_cnt4",   32'(cnt_o),     32'h04);
        q_in = 4'h5;
        step(3);
        cnt_ready = 1'b1;
        step(1);
        check("ov_same_cnt",   32'(cnt_o),     32'h05);
        check("ov_same_valid", 32'(cnt_valid), 32'd1);
        check("ov_same_err",   32'(ovr_err),   32'd0);
        step(1);
        check("ov_same_drain", 32'(cnt_valid), 32'd0);
        check("ov_skip",       32'(skip_err),  32'd0);
        cnt_ready = 1'b0;

        // ---- 6. reset mid-stream with ext=2 ----
        q_in = 4'h0;
        step(8);
        check("rm_cnt10", 32'(cnt_o), 32'h10);
        q_in = 4'hF;
        step(8);
        q_in = 4'h0;
        step(8);
        check("rm_cnt20", 32'(cnt_o),     32'h20);
        check("rm_valid", 32'(cnt_valid), 32'd1);
        rst = 1'b0; q_in = 4'h9;
        step(2);
        check("rm_rst_cnt",   32'(cnt_o),     32'h00);
        check("rm_rst_valid", 32'(cnt_valid), 32'd0);
        check("rm_rst_skip",  32'(skip_err),  32'd0);
        check("rm_rst_ovr",   32'(ovr_err),   32'd0);
        rst = 1'b1;
        step(3);
        check("rm_early_valid", 32'(cnt_valid), 32'd0);
        step(1);
        check("rm_cnt9",  32'(cnt_o),     32'h09);
        check("rm_valid9", 32'(cnt_valid), 32'd1);
        check("rm_skip9", 32'(skip_err),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule : tb_ripple_count_sampler
`default_nettype wire
